// File: rtl/instr_mem_sync_if.sv
// Fetch/program bus between the PC/fetch stage and the instruction memory.
// rsp_perr exists only when INSTR_MEM_PARITY_EN is defined.
interface instr_mem_sync_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              init_busy;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_err;
`ifdef INSTR_MEM_PARITY_EN
  logic              rsp_perr;

  modport master (
    input  init_busy, prog_err, req_ready, rsp_valid, rsp_instr, rsp_err, rsp_perr,
    output prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready
  );
  modport slave (
    output init_busy, prog_err, req_ready, rsp_valid, rsp_instr, rsp_err, rsp_perr,
    input  prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready
  );
`else
  modport master (
    input  init_busy, prog_err, req_ready, rsp_valid, rsp_instr, rsp_err,
    output prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready
  );
  modport slave (
    output init_busy, prog_err, req_ready, rsp_valid, rsp_instr, rsp_err,
    input  prog_we, prog_addr, prog_data, req_valid, req_addr, rsp_ready
  );
`endif
endinterface

// File: rtl/instr_mem_sync.sv
// Direct-indexed instruction memory with post-reset NOP sweep, program-load port
// and a 1-cycle valid/ready fetch path. Optional word parity: INSTR_MEM_PARITY_EN.
module instr_mem_sync #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input logic             clk,
  input logic             rst_n,
  instr_mem_sync_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif
  // One extra bit so DEPTH == 2**ADDR_W is representable and every address is legal.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef INSTR_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              prog_err_q, prog_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_perr_q, rsp_perr_d;

  logic              req_ready_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_idx_c;
  logic [WORD_W-1:0] mem_wdata_c;
  logic [WORD_W-1:0] rd_word_c;
  logic              req_in_range_c;
  logic              prog_in_range_c;

  assign req_in_range_c  = {1'b0, bus.req_addr}  < DEPTH_X;
  assign prog_in_range_c = {1'b0, bus.prog_addr} < DEPTH_X;
  assign rd_word_c       = mem[bus.req_addr[IDX_W-1:0]];

  // State, sweep counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      prog_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= NOP_VALUE;
      rsp_err_q   <= 1'b0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prog_err_q  <= prog_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  // Single write port shared by the init sweep and program load; reads see the old word.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prog_err_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    rsp_perr_d  = rsp_perr_q;
    req_ready_c = 1'b0;
    mem_we_c    = 1'b0;
    mem_idx_c   = cnt_q;
    mem_wdata_c = encode(NOP_VALUE);
    unique case (state_q)
      INIT: begin
        mem_we_c   = 1'b1;
        prog_err_d = bus.prog_we;
        cnt_d      = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        req_ready_c = !rsp_valid_q || bus.rsp_ready;
        if (bus.prog_we) begin
          if (prog_in_range_c) begin
            mem_we_c    = 1'b1;
            mem_idx_c   = bus.prog_addr[IDX_W-1:0];
            mem_wdata_c = encode(bus.prog_data);
          end else begin
            prog_err_d = 1'b1;
          end
        end
        if (bus.req_valid && req_ready_c) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !req_in_range_c;
          rsp_instr_d = req_in_range_c ? rd_word_c[DATA_W-1:0] : NOP_VALUE;
          rsp_perr_d  = req_in_range_c && (^rd_word_c);
        end else if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.init_busy = (state_q == INIT);
  assign bus.prog_err  = prog_err_q;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_err   = rsp_err_q;
`ifdef INSTR_MEM_PARITY_EN
  assign bus.rsp_perr  = rsp_perr_q;
`else
  logic unused_perr;
  assign unused_perr = rsp_perr_q;
`endif

endmodule
